data_memory_lsu: RTL

Parametrised RV64 data memory with a load/store unit front end. It supersedes the single-cycle doubleword-only data memory: byte/half/word/double accesses selected by RISC-V funct3, sign/zero extension, alignment and range checking, programmable wait-state latency, and valid/ready handshakes on request and response. Sits between the MEM stage and the data array; one request in flight at a time.

---
 rtl/data_memory_lsu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_lsu
// Description : RV64 data memory with a load/store front end. Handles
//               byte/half/word/double accesses selected by funct3, sign/zero
//               extension, alignment and range checks, programmable wait
//               states and valid/ready handshakes. One request in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int         IW     = $clog2(DEPTH_WORDS);
  localparam int         AW     = IW + 3;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [63:0] mem [DEPTH_WORDS];

  // The request being executed: live inputs while idle (zero-latency commit
  // happens on the accept edge), captured copy afterwards.
  logic        eff_write;
  logic [2:0]  eff_funct3;
  logic [63:0] eff_addr;
  logic [63:0] eff_wdata;
  logic [IW-1:0] idx;
  logic [2:0]  off;
  logic        illegal, misalign, out_of_range, acc_error;
  logic [63:0] dword, shifted, load_val, merged, wshift;
  logic [7:0]  size_mask, byte_en;
  logic        go_resp;

  assign eff_write  = (state_q == S_IDLE) ? req_write  : write_q;
  assign eff_funct3 = (state_q == S_IDLE) ? req_funct3 : funct3_q;
  assign eff_addr   = (state_q == S_IDLE) ? req_addr   : addr_q;
  assign eff_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;
  assign idx        = eff_addr[AW-1:3];
  assign off        = eff_addr[2:0];

  // Access legality: funct3 encoding, natural alignment and array bounds.
  always_comb begin
    illegal      = eff_write ? eff_funct3[2] : (eff_funct3 == 3'b111);
    out_of_range = |eff_addr[63:AW];
    case (eff_funct3[1:0])
      2'b01:   misalign = eff_addr[0];
      2'b10:   misalign = |eff_addr[1:0];
      2'b11:   misalign = |eff_addr[2:0];
      default: misalign = 1'b0;
    endcase
    acc_error = illegal | misalign | out_of_range;
  end

  // Load extraction/extension and store byte-enable merge on the addressed doubleword.
  always_comb begin
    dword   = mem[idx];
    shifted = dword >> {off, 3'b000};
    case (eff_funct3[1:0])
      2'b00:   load_val = eff_funct3[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = eff_funct3[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = eff_funct3[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
    case (eff_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    byte_en = size_mask << off;
    wshift  = eff_wdata << {off, 3'b000};
    merged  = dword;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) merged[i*8 +: 8] = wshift[i*8 +: 8];
    end
  end

  // Next-state logic: handshake FSM, wait counter, request capture, response latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    go_resp = (state_d == S_RESP) && (state_q != S_RESP);
    if (go_resp) begin
      error_d = acc_error;
      rdata_d = (acc_error || eff_write) ? 64'd0 : load_val;
    end
  end

  // Control and response registers; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      rdata_q  <= 64'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Array write at the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && eff_write && !acc_error) begin
      mem[idx] <= merged;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule
`default_nettype wire
